mem_line_port: RTL

//  Multi-cycle memory port model used as the CPU-side memory behind the pipelined CPU benches.
//  - Serves aligned LINE_WORDS-word line reads and single-word writes.
//  - Every access takes a fixed LATENCY cycles; the requester is told when to wait and when the access is done.
//  - One instance is used for the instruction side and one for the data side.

---
 rtl/mem_line_port.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_line_port.sv
// Multi-cycle memory port: aligned LINE_WORDS-word line reads, single-word writes.
// Ports: clk/reset_n, req_read/req_write/req_addr/wr_data in; busy, rd_valid/rd_line, wr_done/written_addr out.
module mem_line_port #(
  parameter int    WORD_SIZE  = 16,
  parameter int    LINE_WORDS = 4,
  parameter int    DEPTH      = 1024,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_read,
  input  logic                            req_write,
  input  logic [WORD_SIZE-1:0]            req_addr,
  input  logic [WORD_SIZE-1:0]            wr_data,
  output logic                            busy,
  output logic                            rd_valid,
  output logic [LINE_WORDS*WORD_SIZE-1:0] rd_line,
  output logic                            wr_done,
  output logic [WORD_SIZE-1:0]            written_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LW = LINE_WORDS * WORD_SIZE;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_done_q, wr_done_d;
  logic [LW-1:0]        rd_line_q, rd_line_d;
  logic [WORD_SIZE-1:0] waddr_q, waddr_d;

  logic          accept;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] base;
  logic [LW-1:0] line_rd;

  assign accept = (state_q == IDLE) && (req_read || req_write);
  assign done   = (state_q != IDLE) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a simultaneous read+write takes the write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_write)     state_d = WR_WAIT;
        else if (req_read) state_d = RD_WAIT;
      end
      RD_WAIT,
      WR_WAIT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line gather from the aligned, wrapped base address.
  always_comb begin
    base    = addr_q[AW-1:0] & ~AW'(LINE_WORDS - 1);
    line_rd = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line_rd[i*WORD_SIZE +: WORD_SIZE] = mem[base | AW'(i)];
    end
  end

  // Output / datapath
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    rd_line_d  = rd_line_q;
    waddr_d    = waddr_q;
    mem_we     = 1'b0;
    if (accept) begin
      addr_d = req_addr;
      data_d = wr_data;
      cnt_d  = CW'(LATENCY - 1);
    end else if (state_q != IDLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (state_q == RD_WAIT) begin
        rd_valid_d = 1'b1;
        rd_line_d  = line_rd;
      end else begin
        wr_done_d = 1'b1;
        waddr_d   = addr_q;
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_line_q  <= '0;
      waddr_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      rd_line_q  <= rd_line_d;
      waddr_q    <= waddr_d;
    end
  end

  // Storage is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem[addr_q[AW-1:0]] <= data_q;
    end
  end

  assign busy         = (state_q != IDLE);
  assign rd_valid     = rd_valid_q;
  assign wr_done      = wr_done_q;
  assign rd_line      = rd_line_q;
  assign written_addr = waddr_q;

endmodule
